// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side engine for the synchronous FIFO.
// Pops words through the FIFO read port (1-cycle registered read latency)
// and presents them as a valid/ready stream through a 2-entry prefetch buffer.
// Optional macro READER_LAST_EN adds the m_last burst marker and beat counter.

module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       level
`ifdef READER_LAST_EN
  ,
  output logic             m_last
`endif
);

  // A burst length outside 1..256 cannot be represented by the 8-bit beat counter.
  if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_burst_len_check
    $error("fifo_stream_reader: BURST_LEN must be in 1..256");
  end

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       cnt;
  logic             inflight;
  logic             pop;
  logic [1:0]       cnt_after_pop;
  logic [2:0]       occupancy;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = slot0;
  assign level   = cnt;

  // Read strobe: only request a word when a buffer slot is guaranteed for it
  // once this cycle's pop and the word already in flight are accounted for.
  always_comb begin
    pop           = (cnt != 2'd0) & m_ready;
    cnt_after_pop = cnt - {1'b0, pop};
    occupancy     = {1'b0, cnt_after_pop} + {2'b00, inflight};
    fifo_rd_en    = !fifo_empty & !rst & !flush & (occupancy < 3'd2);
  end

  // Buffer update: shift on pop, then land the returning word in the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0    <= '0;
      slot1    <= '0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else if (flush) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      cnt      <= cnt_after_pop + {1'b0, inflight};
      if (pop) begin
        slot0 <= slot1;
      end
      if (inflight) begin
        if (cnt_after_pop == 2'd0) begin
          slot0 <= fifo_rd_data;
        end else begin
          slot1 <= fifo_rd_data;
        end
      end
    end
  end

`ifdef READER_LAST_EN
  logic [7:0] beat;

  // Beat counter: counts accepted beats and wraps after a full burst.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beat <= 8'd0;
    end else if (pop) begin
      if (beat == 8'(BURST_LEN - 1)) begin
        beat <= 8'd0;
      end else begin
        beat <= beat + 8'd1;
      end
    end
  end

  assign m_last = m_valid & (beat == 8'(BURST_LEN - 1));
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized and directed bench for fifo_stream_reader.
// A queue-based FIFO and a queue-based model of the output buffer predict
// every output on every cycle. Define READER_LAST_EN to cover m_last.

module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int BL    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       level;
`ifdef READER_LAST_EN
  logic             m_last;
`endif

  fifo_stream_reader #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .level(level)
`ifdef READER_LAST_EN
    ,
    .m_last(m_last)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int               checks;
  int               failures;
  int               cyc;
  int               rd_count;
  int               beats;
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] out_log[$];
  int               out_cyc[$];
  bit               m_inflight;
  logic [WIDTH-1:0] inflight_word;
  bit               s_rd;
  bit               s_pop;
  bit               s_clear;
`ifdef READER_LAST_EN
  bit               s_last;
  bit               exp_last_log[$];
`endif

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, want);
    end
  endtask

  // Push one word into the modelled FIFO.
  task automatic apply_stimulus(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Compare DUT outputs with the model mid-cycle and latch what the next edge will do.
  task automatic check_output();
    bit exp_valid;
    bit exp_pop;
    bit exp_rd;
    int occ;
    exp_valid = (model_q.size() != 0);
    exp_pop   = exp_valid && (m_ready === 1'b1);
    occ       = model_q.size() + int'(m_inflight) - int'(exp_pop);
    exp_rd    = (fq.size() != 0) && (rst === 1'b0) && (flush === 1'b0) && (occ < 2);
    compare("m_valid", 32'(m_valid), 32'(exp_valid));
    compare("level", 32'(level), model_q.size());
    compare("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    if (exp_valid) compare("m_data", 32'(m_data), 32'(model_q[0]));
`ifdef READER_LAST_EN
    s_last = exp_valid && (beats == BL - 1);
    compare("m_last", 32'(m_last), 32'(s_last));
`endif
    s_rd    = (fifo_rd_en === 1'b1);
    s_pop   = exp_pop;
    s_clear = (rst === 1'b1) || (flush === 1'b1);
  endtask

  // One clock: check at the falling edge, advance FIFO and model at the rising edge.
  task automatic tick();
    bit               got;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    check_output();
    @(posedge clk);
    got = 1'b0;
    w   = '0;
    if (s_rd && fq.size() != 0) begin
      w = fq.pop_front();
      got = 1'b1;
      rd_count++;
    end
    if (s_clear) begin
      model_q.delete();
      beats = 0;
    end else begin
      if (s_pop) begin
`ifdef READER_LAST_EN
        exp_last_log.push_back(s_last);
`endif
        out_log.push_back(model_q.pop_front());
        out_cyc.push_back(cyc);
        beats = (beats + 1) % BL;
      end
      if (m_inflight) model_q.push_back(inflight_word);
    end
    m_inflight    = got && !s_clear;
    inflight_word = w;
    cyc++;
    #1;
    fifo_rd_data = got ? w : WIDTH'($urandom);
    fifo_empty   = (fq.size() == 0);
  endtask

  task automatic run_until_idle(input int bound);
    int n;
    n = 0;
    while ((fq.size() != 0 || model_q.size() != 0 || m_inflight) && n < bound) begin
      tick();
      n++;
    end
    compare("idle_within_bound", 32'(n < bound), 32'd1);
    tick();
  endtask

  initial begin
    int base;
    int n0;
    int rc;
    checks = 0; failures = 0; cyc = 0; rd_count = 0; beats = 0;
    m_inflight = 1'b0; inflight_word = '0;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;

    // Reset with a non-empty FIFO: no reads, no output.
    apply_stimulus(8'h11); apply_stimulus(8'h12); apply_stimulus(8'h13);
    @(posedge clk); #1;
    tick(); tick();
    compare("reset_m_data", 32'(m_data), 32'h0);
    compare("reset_no_reads", rd_count, 0);
    rst = 1'b0;
    tick();
    compare("first_read_after_reset", rd_count, 1);

    // Drain three words to empty.
    m_ready = 1'b1;
    run_until_idle(50);
    compare("drain_reads", rd_count, 3);
    compare("drain_beats", out_log.size(), 3);
    compare("drain_last_word", 32'(out_log[2]), 32'h13);

    // Latency and back-to-back streaming of eight words.
    base = out_log.size(); n0 = cyc;
    for (int i = 1; i <= 8; i++) apply_stimulus(WIDTH'(i));
    repeat (12) tick();
    compare("stream_len", out_log.size() - base, 8);
    for (int i = 0; i < 8 && base + i < out_log.size(); i++) begin
      compare("stream_data", 32'(out_log[base + i]), i + 1);
      compare("stream_cycle", out_cyc[base + i], n0 + 2 + i);
    end

    // Backpressure after the first beat.
    base = out_log.size();
    for (int i = 1; i <= 7; i++) apply_stimulus(WIDTH'(i));
    repeat (3) tick();
    m_ready = 1'b0;
    repeat (4) tick();
    compare("bp_level", 32'(level), 32'd2);
    compare("bp_head", 32'(m_data), 32'h02);
    compare("bp_no_read", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    run_until_idle(50);
    compare("bp_len", out_log.size() - base, 7);
    for (int i = 0; i < 7 && base + i < out_log.size(); i++)
      compare("bp_order", 32'(out_log[base + i]), i + 1);

    // Flush while a word is returning with one word buffered.
    m_ready = 1'b0;
    base = out_log.size();
    apply_stimulus(8'hA1); apply_stimulus(8'hA2); apply_stimulus(8'hA3);
    tick(); tick();
    compare("flush_setup_level", 32'(level), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    compare("flush_valid", 32'(m_valid), 32'd0);
    compare("flush_level", 32'(level), 32'd0);
    rc = rd_count;
    tick();
    compare("read_resumes", rd_count, rc + 1);
    m_ready = 1'b1;
    run_until_idle(50);
    compare("flush_survivors", out_log.size() - base, 1);
    compare("flush_survivor_word", 32'(out_log[out_log.size() - 1]), 32'hA3);

`ifdef READER_LAST_EN
    // Burst markers over ten beats, then restart of the count by reset.
    rst = 1'b1; tick(); rst = 1'b0;
    base = out_log.size();
    for (int i = 0; i < 10; i++) apply_stimulus(WIDTH'(8'h40 + i));
    run_until_idle(60);
    for (int i = 0; i < 10 && base + i < exp_last_log.size(); i++)
      compare("last_beat", 32'(exp_last_log[base + i]), 32'((i == 3) || (i == 7)));
    base = out_log.size();
    for (int i = 0; i < 10; i++) apply_stimulus(WIDTH'(8'h60 + i));
    rc = 0;
    while (out_log.size() < base + 2 && rc < 40) begin tick(); rc++; end
    rst = 1'b1; tick(); rst = 1'b0;
    base = out_log.size();
    run_until_idle(60);
    compare("post_reset_beat2_last", 32'(exp_last_log[base + 1]), 32'd0);
    compare("post_reset_beat4_last", 32'(exp_last_log[base + 3]), 32'd1);
`endif

    // Randomized traffic with flushes and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 12) apply_stimulus(WIDTH'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 120) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; m_ready = 1'b1;
    run_until_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
